// File: rtl/fpnew_lane_sequencer.sv
// fpnew_lane_sequencer
// Runs a packed (vectorial) FP operation through one scalar lane unit by
// issuing the lanes one after another and reassembling the packed result.
// A scalar operation issues only lane 0. The upper lanes of its result are
// filled with the extension bit that the unit returns for lane 0.
module fpnew_lane_sequencer #(
    parameter int unsigned Width       = 32,
    parameter int unsigned FpWidth     = 8,
    parameter int unsigned NumOperands = 3,
    parameter int unsigned TagWidth    = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [NumOperands*Width-1:0]   operands_i,
    input  logic [3:0]                     op_i,
    input  logic                           op_mod_i,
    input  logic [2:0]                     rnd_mode_i,
    input  logic                           vectorial_op_i,
    input  logic [TagWidth-1:0]            tag_i,
    input  logic                           flush_i,
    output logic                           unit_valid_o,
    input  logic                           unit_ready_i,
    output logic [NumOperands*FpWidth-1:0] unit_operands_o,
    output logic [3:0]                     unit_op_o,
    output logic                           unit_op_mod_o,
    output logic [2:0]                     unit_rnd_mode_o,
    output logic                           unit_flush_o,
    input  logic                           unit_valid_i,
    output logic                           unit_ready_o,
    input  logic [FpWidth-1:0]             unit_result_i,
    input  logic [4:0]                     unit_status_i,
    input  logic                           unit_ext_bit_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [Width-1:0]               result_o,
    output logic [4:0]                     status_o,
    output logic [TagWidth-1:0]            tag_o,
    output logic                           busy_o
);

    localparam int unsigned NUM_LANES = Width / FpWidth;
    localparam int unsigned CNT_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                         state_q, state_d;
    // issue_cnt needs one extra bit: it runs one past the last lane to stop issue
    logic [CNT_W:0]                 issue_cnt_q;
    logic [CNT_W-1:0]               collect_cnt_q;
    logic [CNT_W-1:0]               last_lane_q;
    logic [NumOperands*Width-1:0]   operands_q;
    logic                           vec_q;
    logic [TagWidth-1:0]            tag_q;
    // Accumulators are private to the running op; output regs change only on completion
    logic [Width-1:0]               result_acc_q;
    logic [4:0]                     status_acc_q;
    logic                           ext_q;
    logic [Width-1:0]               result_q;
    logic [4:0]                     status_q;
    logic [TagWidth-1:0]            tag_out_q;

    logic                           accept;
    logic                           issue_fire;
    logic                           collect_fire;
    logic                           last_collect;
    logic [CNT_W-1:0]               lane_sel;
    logic [Width-1:0]               acc_next;
    logic [Width-1:0]               packed_res;
    logic [4:0]                     status_next;
    logic                           ext_next;

    assign accept       = in_valid_i & in_ready_o;
    assign issue_fire   = unit_valid_o & unit_ready_i;
    assign collect_fire = unit_ready_o & unit_valid_i;
    assign last_collect = collect_fire & (collect_cnt_q == last_lane_q);
    assign unit_flush_o = flush_i;
    assign result_o     = result_q;
    assign status_o     = status_q;
    assign tag_o        = tag_out_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush overrides every handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_collect) state_d = DONE;
            DONE:    if (out_ready_i) state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // FSM outputs: handshakes toward upstream, unit and downstream
    always_comb begin
        in_ready_o   = ~flush_i & ((state_q == IDLE) | ((state_q == DONE) & out_ready_i));
        unit_valid_o = (state_q == RUN) & (issue_cnt_q <= {1'b0, last_lane_q});
        unit_ready_o = (state_q == RUN);
        out_valid_o  = (state_q == DONE);
        busy_o       = (state_q != IDLE);
    end

    // Lane operand selection; the index is parked at 0 once all lanes are issued
    always_comb begin
        lane_sel        = unit_valid_o ? issue_cnt_q[CNT_W-1:0] : '0;
        unit_operands_o = '0;
        for (int k = 0; k < NumOperands; k++) begin
            unit_operands_o[k*FpWidth +: FpWidth] = operands_q[k*Width + lane_sel*FpWidth +: FpWidth];
        end
    end

    // Merge the collected lane into the accumulator and build the final packed result
    always_comb begin
        acc_next = result_acc_q;
        if (collect_fire) acc_next[collect_cnt_q*FpWidth +: FpWidth] = unit_result_i;
        ext_next    = (collect_fire && collect_cnt_q == '0) ? unit_ext_bit_i : ext_q;
        status_next = status_acc_q | (collect_fire ? unit_status_i : 5'b0);
        packed_res  = acc_next;
        if (!vec_q) begin
            for (int l = 1; l < NUM_LANES; l++) begin
                packed_res[l*FpWidth +: FpWidth] = {FpWidth{ext_next}};
            end
        end
    end

    // Issue/collect counters
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || accept) begin
            issue_cnt_q   <= '0;
            collect_cnt_q <= '0;
        end else begin
            if (issue_fire)                   issue_cnt_q   <= issue_cnt_q + 1'b1;
            if (collect_fire && !last_collect) collect_cnt_q <= collect_cnt_q + 1'b1;
        end
    end

    // Request capture and lane accumulation (no reset needed: qualified by state)
    always_ff @(posedge clk_i) begin
        if (accept) begin
            operands_q      <= operands_i;
            unit_op_o       <= op_i;
            unit_op_mod_o   <= op_mod_i;
            unit_rnd_mode_o <= rnd_mode_i;
            tag_q           <= tag_i;
            vec_q           <= vectorial_op_i;
            last_lane_q     <= vectorial_op_i ? CNT_W'(NUM_LANES - 1) : '0;
            status_acc_q    <= '0;
        end else if (collect_fire) begin
            result_acc_q    <= acc_next;
            status_acc_q    <= status_next;
            ext_q           <= ext_next;
        end
    end

    // Output registers: loaded on the final collect, held otherwise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q  <= '0;
            status_q  <= '0;
            tag_out_q <= '0;
        end else if (last_collect && !flush_i) begin
            result_q  <= packed_res;
            status_q  <= status_next;
            tag_out_q <= tag_q;
        end
    end

endmodule

// File: tb/tb_fpnew_lane_sequencer.sv
// Directed testbench for fpnew_lane_sequencer with a zero-latency lane unit model.
// The model returns operand 2's lane byte as the result, operand 1's lane byte
// bits [4:0] as status and bit 7 as the extension bit.
module tb_fpnew_lane_sequencer;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [95:0] operands_i = '0;
    logic [3:0]  op_i = '0;
    logic        op_mod_i = 1'b0;
    logic [2:0]  rnd_mode_i = '0;
    logic        vectorial_op_i = 1'b0;
    logic [3:0]  tag_i = '0;
    logic        flush_i = 1'b0;
    logic        unit_valid_o;
    logic        unit_ready_i = 1'b1;
    logic [23:0] unit_operands_o;
    logic [3:0]  unit_op_o;
    logic        unit_op_mod_o;
    logic [2:0]  unit_rnd_mode_o;
    logic        unit_flush_o;
    logic        unit_valid_i;
    logic        unit_ready_o;
    logic [7:0]  unit_result_i;
    logic [4:0]  unit_status_i;
    logic        unit_ext_bit_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] result_o;
    logic [4:0]  status_o;
    logic [3:0]  tag_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int issue_count = 0;

    always #5 clk = ~clk;

    assign unit_valid_i   = unit_valid_o & unit_ready_i;
    assign unit_result_i  = unit_operands_o[23:16];
    assign unit_status_i  = unit_operands_o[12:8];
    assign unit_ext_bit_i = unit_operands_o[15];

    always @(posedge clk) if (unit_valid_o && unit_ready_i) issue_count <= issue_count + 1;

    fpnew_lane_sequencer dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .operands_i(operands_i), .op_i(op_i), .op_mod_i(op_mod_i), .rnd_mode_i(rnd_mode_i),
        .vectorial_op_i(vectorial_op_i), .tag_i(tag_i), .flush_i(flush_i),
        .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i), .unit_operands_o(unit_operands_o),
        .unit_op_o(unit_op_o), .unit_op_mod_o(unit_op_mod_o), .unit_rnd_mode_o(unit_rnd_mode_o),
        .unit_flush_o(unit_flush_o), .unit_valid_i(unit_valid_i), .unit_ready_o(unit_ready_o),
        .unit_result_i(unit_result_i), .unit_status_i(unit_status_i), .unit_ext_bit_i(unit_ext_bit_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
        .status_o(status_o), .tag_o(tag_o), .busy_o(busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2,
                           input logic vec, input logic [3:0] tag);
        in_valid_i     = 1'b1;
        operands_i     = {o2, o1, o0};
        vectorial_op_i = vec;
        tag_i          = tag;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
        n_checks++; if (unit_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_unit_valid got %b want 0", unit_valid_o); end
        n_checks++; if (unit_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_unit_ready got %b want 0", unit_ready_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
        n_checks++; if ({result_o, status_o, tag_o} !== 41'h0) begin n_fail++; $display("FAIL reset_regs got %h/%h/%h want 0", result_o, status_o, tag_o); end
    endtask

    task automatic test_scalar();
        set_req(32'h11223344, 32'h00000081, 32'h0000003C, 1'b0, 4'h5);
        op_i = 4'h0; op_mod_i = 1'b1; rnd_mode_i = 3'b010;
        tick();
        in_valid_i = 1'b0;
        n_checks++; if (unit_valid_o !== 1'b1) begin n_fail++; $display("FAIL scalar_issue got %b want 1", unit_valid_o); end
        n_checks++; if (unit_operands_o !== 24'h3C8144) begin n_fail++; $display("FAIL scalar_operands got %h want 3c8144", unit_operands_o); end
        n_checks++; if ({unit_op_o, unit_op_mod_o, unit_rnd_mode_o} !== 8'b0000_1_010) begin n_fail++; $display("FAIL scalar_opfields got %b want 00001010", {unit_op_o, unit_op_mod_o, unit_rnd_mode_o}); end
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL scalar_early_out got %b want 0", out_valid_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL scalar_out_valid got %b want 1", out_valid_o); end
        n_checks++; if (result_o !== 32'hFFFFFF3C) begin n_fail++; $display("FAIL scalar_result got %h want ffffff3c", result_o); end
        n_checks++; if (status_o !== 5'h01) begin n_fail++; $display("FAIL scalar_status got %h want 01", status_o); end
        n_checks++; if (tag_o !== 4'h5) begin n_fail++; $display("FAIL scalar_tag got %h want 5", tag_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL scalar_idle got %b%b want 00", out_valid_o, busy_o); end
        n_checks++; if (result_o !== 32'hFFFFFF3C) begin n_fail++; $display("FAIL scalar_hold got %h want ffffff3c", result_o); end
    endtask

    task automatic test_vector();
        logic [31:0] o0, o1, o2;
        logic [23:0] exp;
        o0 = 32'hDDCCBBAA; o1 = 32'h00100001; o2 = 32'h44332211;
        set_req(o0, o1, o2, 1'b1, 4'hA);
        tick();
        in_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = {o2[i*8 +: 8], o1[i*8 +: 8], o0[i*8 +: 8]};
            n_checks++; if (unit_valid_o !== 1'b1 || unit_operands_o !== exp) begin n_fail++; $display("FAIL vector_lane%0d got %b/%h want 1/%h", i, unit_valid_o, unit_operands_o, exp); end
            n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL vector_early_out%0d got %b want 0", i, out_valid_o); end
            tick();
        end
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL vector_out_valid got %b want 1", out_valid_o); end
        n_checks++; if (result_o !== 32'h44332211) begin n_fail++; $display("FAIL vector_result got %h want 44332211", result_o); end
        n_checks++; if (status_o !== 5'h11) begin n_fail++; $display("FAIL vector_status got %h want 11", status_o); end
        n_checks++; if (tag_o !== 4'hA) begin n_fail++; $display("FAIL vector_tag got %h want a", tag_o); end
        tick();
    endtask

    task automatic test_unit_backpressure();
        int start;
        start = issue_count;
        set_req(32'hDDCCBBAA, 32'h00100001, 32'h44332211, 1'b1, 4'h3);
        tick();
        in_valid_i = 1'b0;
        tick(); tick();
        unit_ready_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            n_checks++; if (unit_valid_o !== 1'b1 || unit_operands_o !== 24'h3310CC) begin n_fail++; $display("FAIL stall_lane2_c%0d got %b/%h want 1/3310cc", j, unit_valid_o, unit_operands_o); end
            tick();
        end
        unit_ready_i = 1'b1;
        tick(); tick();
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid got %b want 1", out_valid_o); end
        n_checks++; if (result_o !== 32'h44332211 || status_o !== 5'h11) begin n_fail++; $display("FAIL stall_result got %h/%h want 44332211/11", result_o, status_o); end
        n_checks++; if (issue_count - start !== 4) begin n_fail++; $display("FAIL stall_issue_count got %0d want 4", issue_count - start); end
        tick();
    endtask

    task automatic test_out_backpressure();
        out_ready_i = 1'b0;
        set_req(32'h0, 32'h00000001, 32'h0000005A, 1'b0, 4'h7);
        tick();
        in_valid_i = 1'b0;
        tick();
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (out_valid_o !== 1'b1 || result_o !== 32'h0000005A || tag_o !== 4'h7) begin n_fail++; $display("FAIL obp_hold_c%0d got %b/%h/%h want 1/0000005a/7", j, out_valid_o, result_o, tag_o); end
            n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL obp_in_ready_c%0d got %b want 0", j, in_ready_o); end
            tick();
        end
        set_req(32'h0, 32'h00000004, 32'h0A0B0C0D, 1'b1, 4'h9);
        out_ready_i = 1'b1;
        #1;
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL obp_b2b_ready got %b want 1", in_ready_o); end
        tick();
        in_valid_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL obp_b2b_run got %b%b want 01", out_valid_o, busy_o); end
        n_checks++; if (result_o !== 32'h0000005A) begin n_fail++; $display("FAIL obp_b2b_hold got %h want 0000005a", result_o); end
        tick(); tick(); tick(); tick();
        n_checks++; if (out_valid_o !== 1'b1 || result_o !== 32'h0A0B0C0D || status_o !== 5'h04 || tag_o !== 4'h9) begin n_fail++; $display("FAIL obp_b2b_result got %b/%h/%h/%h want 1/0a0b0c0d/04/9", out_valid_o, result_o, status_o, tag_o); end
        tick();
    endtask

    task automatic test_flush();
        set_req(32'h0, 32'h0, 32'h99887766, 1'b1, 4'h4);
        tick();
        in_valid_i = 1'b0;
        tick(); tick();
        flush_i = 1'b1;
        #1;
        n_checks++; if (unit_flush_o !== 1'b1 || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_fwd got %b/%b want 1/0", unit_flush_o, in_ready_o); end
        tick();
        flush_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || unit_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle got %b%b%b want 000", busy_o, out_valid_o, unit_valid_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_no_out got %b want 0", out_valid_o); end
        set_req(32'h0, 32'h0, 32'h00000012, 1'b0, 4'h6);
        tick();
        in_valid_i = 1'b0;
        tick();
        n_checks++; if (out_valid_o !== 1'b1 || result_o !== 32'h00000012 || tag_o !== 4'h6) begin n_fail++; $display("FAIL flush_next_op got %b/%h/%h want 1/00000012/6", out_valid_o, result_o, tag_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(32'h0, 32'h00000001, 32'h55667788, 1'b1, 4'hB);
        tick();
        in_valid_i = 1'b0;
        tick(); tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || unit_valid_o !== 1'b0 || unit_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got %b%b%b%b want 0000", busy_o, out_valid_o, unit_valid_o, unit_ready_o); end
        n_checks++; if ({result_o, status_o, tag_o} !== 41'h0 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_regs got %h/%h/%h/%b want 0/0/0/1", result_o, status_o, tag_o, in_ready_o); end
        set_req(32'h0, 32'h00000080, 32'h0000007E, 1'b0, 4'h2);
        tick();
        in_valid_i = 1'b0;
        tick();
        n_checks++; if (out_valid_o !== 1'b1 || result_o !== 32'hFFFFFF7E || status_o !== 5'h00 || tag_o !== 4'h2) begin n_fail++; $display("FAIL rstmid_next_op got %b/%h/%h/%h want 1/ffffff7e/00/2", out_valid_o, result_o, status_o, tag_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_scalar();
        test_vector();
        test_unit_backpressure();
        test_out_backpressure();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
